// File: rtl/usb_dev_trans_ctrl.sv
// Device-side USB transaction controller. Accepts tokens addressed to this
// device, runs the data and handshake phases through the shared TX/RX packet
// engines and reports each finished transaction with a one-cycle done pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a token; SOF tokens only raise SOFRcvd
// CHK_EP    | endpoint status valid; choose data, handshake or receive
// TX_WAIT   | waiting for TX engine idle; strobe WEn when it is
// TX_DROP   | WEn low for one cycle after the strobe
// TX_END    | waiting for TX engine to finish the packet
// RX_WAIT   | waiting for RX engine idle; strobe REn when it is
// RX_DROP   | REn low for one cycle after the strobe
// RX_END    | waiting for RX engine to finish; evaluate RXStatus
// DONE      | one-cycle transDone pulse
module usb_dev_trans_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tokenRdy,
  input  logic [3:0] tokenPID,
  input  logic [6:0] tokenAddr,
  input  logic [3:0] tokenEndP,
  input  logic [6:0] devAddr,
  output logic [3:0] endPSel,
  input  logic       epReady,
  input  logic       epStall,
  input  logic       epIsoEn,
  input  logic       epDataSeq,
  input  logic       sendPacketRdy,
  output logic       sendPacketWEn,
  output logic [3:0] sendPacketPID,
  input  logic       getPacketRdy,
  output logic       getPacketREn,
  input  logic [7:0] RXStatus,
  output logic       SOFRcvd,
  output logic       transDone,
  output logic [1:0] transType,
  output logic [1:0] transResult
);

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hd;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hb;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'ha;
  localparam logic [3:0] PID_STALL = 4'he;

  localparam logic [1:0] TYPE_SETUP = 2'd0;
  localparam logic [1:0] TYPE_IN    = 2'd1;
  localparam logic [1:0] TYPE_OUT   = 2'd2;

  localparam logic [1:0] RES_ACK   = 2'd0;
  localparam logic [1:0] RES_NAK   = 2'd1;
  localparam logic [1:0] RES_STALL = 2'd2;
  localparam logic [1:0] RES_ERR   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_CHK_EP, S_TX_WAIT, S_TX_DROP, S_TX_END,
    S_RX_WAIT, S_RX_DROP, S_RX_END, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] endp_q, endp_d;
  logic [1:0] type_q, type_d;
  logic [1:0] result_q, result_d;
  logic [3:0] pid_q, pid_d;          // PID presented between sends
  logic [3:0] tx_pid_q, tx_pid_d;    // PID queued for the next send
  logic       in_data_q, in_data_d;  // queued send is IN data, not a handshake
  logic       stall_q, stall_d;
  logic       ready_q, ready_d;
  logic       iso_q, iso_d;
  logic       sof_q, sof_d;
  logic       wen, ren, done;
  logic       rx_err;
  logic       rx_unused;

  assign rx_err    = (RXStatus[5:0] != 6'd0);
  assign rx_unused = RXStatus[7];

  // Next-state, datapath loads and strobe decode.
  always_comb begin
    state_d   = state_q;
    endp_d    = endp_q;
    type_d    = type_q;
    result_d  = result_q;
    pid_d     = pid_q;
    tx_pid_d  = tx_pid_q;
    in_data_d = in_data_q;
    stall_d   = stall_q;
    ready_d   = ready_q;
    iso_d     = iso_q;
    sof_d     = 1'b0;
    wen       = 1'b0;
    ren       = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tokenRdy) begin
          if (tokenPID == PID_SOF) begin
            sof_d = 1'b1;
          end else if (tokenAddr == devAddr) begin
            if (tokenPID == PID_SETUP) begin
              endp_d  = tokenEndP;
              type_d  = TYPE_SETUP;
              state_d = S_CHK_EP;
            end else if (tokenPID == PID_IN) begin
              endp_d  = tokenEndP;
              type_d  = TYPE_IN;
              state_d = S_CHK_EP;
            end else if (tokenPID == PID_OUT) begin
              endp_d  = tokenEndP;
              type_d  = TYPE_OUT;
              state_d = S_CHK_EP;
            end
          end
        end
      end

      S_CHK_EP: begin
        // Endpoint status is only guaranteed here, so keep a copy for
        // the handshake decision after an OUT/SETUP data phase.
        stall_d   = epStall;
        ready_d   = epReady;
        iso_d     = epIsoEn;
        in_data_d = 1'b0;
        if (type_q == TYPE_IN) begin
          if (epStall) begin
            tx_pid_d = PID_STALL;
            result_d = RES_STALL;
            state_d  = S_TX_WAIT;
          end else if (!epReady) begin
            result_d = RES_NAK;
            if (epIsoEn) begin
              state_d = S_DONE;
            end else begin
              tx_pid_d = PID_NAK;
              state_d  = S_TX_WAIT;
            end
          end else begin
            tx_pid_d  = (epIsoEn || !epDataSeq) ? PID_DATA0 : PID_DATA1;
            in_data_d = 1'b1;
            state_d   = S_TX_WAIT;
          end
        end else begin
          state_d = S_RX_WAIT;
        end
      end

      S_TX_WAIT: begin
        if (sendPacketRdy) begin
          wen     = 1'b1;
          pid_d   = tx_pid_q;
          state_d = S_TX_DROP;
        end
      end

      S_TX_DROP: state_d = S_TX_END;

      S_TX_END: begin
        if (sendPacketRdy) begin
          if (in_data_q) begin
            if (iso_q) begin
              result_d = RES_ACK;
              state_d  = S_DONE;
            end else begin
              state_d = S_RX_WAIT;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_RX_WAIT: begin
        if (getPacketRdy) begin
          ren     = 1'b1;
          state_d = S_RX_DROP;
        end
      end

      S_RX_DROP: state_d = S_RX_END;

      S_RX_END: begin
        if (getPacketRdy) begin
          if (type_q == TYPE_IN) begin
            // Host handshake after IN data: only a clean ACK counts.
            result_d = (RXStatus[6] && !rx_err) ? RES_ACK : RES_ERR;
            state_d  = S_DONE;
          end else if (rx_err) begin
            result_d = RES_ERR;
            state_d  = S_DONE;
          end else if (iso_q) begin
            result_d = RES_ACK;
            state_d  = S_DONE;
          end else if (type_q == TYPE_SETUP) begin
            // SETUP must always be accepted, even on a halted endpoint.
            tx_pid_d = PID_ACK;
            result_d = RES_ACK;
            state_d  = S_TX_WAIT;
          end else if (stall_q) begin
            tx_pid_d = PID_STALL;
            result_d = RES_STALL;
            state_d  = S_TX_WAIT;
          end else if (!ready_q) begin
            tx_pid_d = PID_NAK;
            result_d = RES_NAK;
            state_d  = S_TX_WAIT;
          end else begin
            tx_pid_d = PID_ACK;
            result_d = RES_ACK;
            state_d  = S_TX_WAIT;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      endp_q    <= 4'd0;
      type_q    <= 2'd0;
      result_q  <= 2'd0;
      pid_q     <= 4'd0;
      tx_pid_q  <= 4'd0;
      in_data_q <= 1'b0;
      stall_q   <= 1'b0;
      ready_q   <= 1'b0;
      iso_q     <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      endp_q    <= endp_d;
      type_q    <= type_d;
      result_q  <= result_d;
      pid_q     <= pid_d;
      tx_pid_q  <= tx_pid_d;
      in_data_q <= in_data_d;
      stall_q   <= stall_d;
      ready_q   <= ready_d;
      iso_q     <= iso_d;
      sof_q     <= sof_d;
    end
  end

  assign endPSel       = endp_q;
  assign sendPacketWEn = wen;
  // The queued PID is shown during the strobe cycle itself, then held.
  assign sendPacketPID = wen ? tx_pid_q : pid_q;
  assign getPacketREn  = ren;
  assign SOFRcvd       = sof_q;
  assign transDone     = done;
  assign transType     = type_q;
  assign transResult   = result_q;

endmodule

// File: tb/tb_usb_dev_trans_ctrl.sv
// Directed bench for usb_dev_trans_ctrl: token filtering, IN/OUT/SETUP
// flows, handshake selection, timing and mid-transaction reset.
module tb_usb_dev_trans_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tokenRdy = 1'b0;
  logic [3:0] tokenPID = 4'h0;
  logic [6:0] tokenAddr = 7'h0;
  logic [3:0] tokenEndP = 4'h0;
  logic [6:0] devAddr = 7'h05;
  logic [3:0] endPSel;
  logic       epReady = 1'b0;
  logic       epStall = 1'b0;
  logic       epIsoEn = 1'b0;
  logic       epDataSeq = 1'b0;
  logic       sendPacketRdy = 1'b1;
  logic       sendPacketWEn;
  logic [3:0] sendPacketPID;
  logic       getPacketRdy = 1'b1;
  logic       getPacketREn;
  logic [7:0] RXStatus = 8'h00;
  logic       SOFRcvd;
  logic       transDone;
  logic [1:0] transType;
  logic [1:0] transResult;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int wen_cnt = 0, ren_cnt = 0, done_cnt = 0, sof_cnt = 0, viol = 0;
  int wen_t = 0, ren_t = 0, done_t = 0, tok_t = 0;
  logic [3:0] last_pid = 4'h0;
  logic [1:0] d_type = 2'd0, d_res = 2'd0;
  logic prev_wen = 1'b0, prev_ren = 1'b0;

  usb_dev_trans_ctrl dut (
    .clk(clk), .rst(rst), .tokenRdy(tokenRdy), .tokenPID(tokenPID),
    .tokenAddr(tokenAddr), .tokenEndP(tokenEndP), .devAddr(devAddr),
    .endPSel(endPSel), .epReady(epReady), .epStall(epStall),
    .epIsoEn(epIsoEn), .epDataSeq(epDataSeq), .sendPacketRdy(sendPacketRdy),
    .sendPacketWEn(sendPacketWEn), .sendPacketPID(sendPacketPID),
    .getPacketRdy(getPacketRdy), .getPacketREn(getPacketREn),
    .RXStatus(RXStatus), .SOFRcvd(SOFRcvd), .transDone(transDone),
    .transType(transType), .transResult(transResult)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (sendPacketWEn) begin
      wen_cnt  <= wen_cnt + 1;
      last_pid <= sendPacketPID;
      wen_t    <= cyc;
    end
    if (getPacketREn) begin
      ren_cnt <= ren_cnt + 1;
      ren_t   <= cyc;
    end
    if (transDone) begin
      done_cnt <= done_cnt + 1;
      done_t   <= cyc;
      d_type   <= transType;
      d_res    <= transResult;
    end
    if (SOFRcvd) sof_cnt <= sof_cnt + 1;
    if (tokenRdy) tok_t <= cyc;
    if ((sendPacketWEn && getPacketREn) || (sendPacketWEn && prev_wen) ||
        (getPacketREn && prev_ren))
      viol <= viol + 1;
    prev_wen <= sendPacketWEn;
    prev_ren <= getPacketREn;
  end

  task automatic send_token(input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp);
    @(posedge clk); #1;
    tokenRdy  = 1'b1;
    tokenPID  = pid;
    tokenAddr = addr;
    tokenEndP = endp;
    @(posedge clk); #1;
    tokenRdy  = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (done_cnt == base) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no transDone within %0d cycles", n);
    end
  endtask

  task automatic set_ep(input logic rdy, input logic stl, input logic iso,
                        input logic seq, input logic [7:0] rxs);
    epReady = rdy; epStall = stl; epIsoEn = iso; epDataSeq = seq; RXStatus = rxs;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({sendPacketWEn, getPacketREn, transDone, SOFRcvd} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 0000",
               {sendPacketWEn, getPacketREn, transDone, SOFRcvd});
    end
    vectors++;
    if ({endPSel, sendPacketPID, transType, transResult} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_values: got %h want 000",
               {endPSel, sendPacketPID, transType, transResult});
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_in_ack;
    int w0 = wen_cnt, r0 = ren_cnt, d0 = done_cnt;
    set_ep(1'b1, 1'b0, 1'b0, 1'b1, 8'h40);
    send_token(4'h9, 7'h05, 4'd2);
    @(negedge clk);
    vectors++;
    if (endPSel !== 4'd2 || transType !== 2'd1) begin
      miscompares++;
      $display("FAIL in_ack_sel: got ep=%0d type=%0d want ep=2 type=1", endPSel, transType);
    end
    wait_done(d0);
    vectors++;
    if (wen_cnt - w0 !== 1 || last_pid !== 4'hb) begin
      miscompares++;
      $display("FAIL in_ack_send: got n=%0d pid=%h want n=1 pid=b", wen_cnt - w0, last_pid);
    end
    vectors++;
    if (ren_cnt - r0 !== 1 || d_type !== 2'd1 || d_res !== 2'd0) begin
      miscompares++;
      $display("FAIL in_ack_done: got ren=%0d type=%0d res=%0d want 1/1/0",
               ren_cnt - r0, d_type, d_res);
    end
  endtask

  task automatic test_out_stall;
    int w0 = wen_cnt, r0 = ren_cnt, d0 = done_cnt;
    set_ep(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send_token(4'h1, 7'h05, 4'd1);
    wait_done(d0);
    vectors++;
    if (ren_cnt - r0 !== 1 || wen_cnt - w0 !== 1 || last_pid !== 4'he || !(wen_t > ren_t)) begin
      miscompares++;
      $display("FAIL out_stall_seq: got ren=%0d wen=%0d pid=%h want 1 1 e, REn before WEn",
               ren_cnt - r0, wen_cnt - w0, last_pid);
    end
    vectors++;
    if (d_type !== 2'd2 || d_res !== 2'd2) begin
      miscompares++;
      $display("FAIL out_stall_res: got type=%0d res=%0d want 2/2", d_type, d_res);
    end
  endtask

  task automatic test_setup;
    int w0 = wen_cnt, d0 = done_cnt;
    set_ep(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_token(4'hd, 7'h05, 4'd0);
    wait_done(d0);
    vectors++;
    if (wen_cnt - w0 !== 1 || last_pid !== 4'h2 || d_type !== 2'd0 || d_res !== 2'd0) begin
      miscompares++;
      $display("FAIL setup_ack: got wen=%0d pid=%h type=%0d res=%0d want 1 2 0 0",
               wen_cnt - w0, last_pid, d_type, d_res);
    end
  endtask

  task automatic test_out_crc;
    int w0 = wen_cnt, r0 = ren_cnt, d0 = done_cnt;
    set_ep(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    send_token(4'h1, 7'h05, 4'd3);
    wait_done(d0);
    vectors++;
    if (wen_cnt - w0 !== 0 || ren_cnt - r0 !== 1 || d_res !== 2'd3) begin
      miscompares++;
      $display("FAIL out_crc: got wen=%0d ren=%0d res=%0d want 0 1 3",
               wen_cnt - w0, ren_cnt - r0, d_res);
    end
  endtask

  task automatic test_in_nak_timing;
    int w0 = wen_cnt, d0 = done_cnt;
    set_ep(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send_token(4'h9, 7'h05, 4'd4);
    wait_done(d0);
    vectors++;
    if (wen_cnt - w0 !== 1 || last_pid !== 4'ha || d_res !== 2'd1) begin
      miscompares++;
      $display("FAIL in_nak: got wen=%0d pid=%h res=%0d want 1 a 1", wen_cnt - w0, last_pid, d_res);
    end
    vectors++;
    if (done_t - tok_t !== 5) begin
      miscompares++;
      $display("FAIL in_nak_latency: got %0d cycles want 5", done_t - tok_t);
    end
  endtask

  task automatic test_in_iso;
    int w0 = wen_cnt, r0 = ren_cnt, d0 = done_cnt;
    set_ep(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    send_token(4'h9, 7'h05, 4'd5);
    wait_done(d0);
    vectors++;
    if (wen_cnt - w0 !== 0 || d_res !== 2'd1) begin
      miscompares++;
      $display("FAIL iso_nak: got wen=%0d res=%0d want 0 1", wen_cnt - w0, d_res);
    end
    d0 = done_cnt;
    set_ep(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    send_token(4'h9, 7'h05, 4'd5);
    wait_done(d0);
    vectors++;
    if (wen_cnt - w0 !== 1 || last_pid !== 4'h3 || ren_cnt - r0 !== 0 || d_res !== 2'd0) begin
      miscompares++;
      $display("FAIL iso_data: got wen=%0d pid=%h ren=%0d res=%0d want 1 3 0 0",
               wen_cnt - w0, last_pid, ren_cnt - r0, d_res);
    end
  endtask

  task automatic test_filter;
    int w0 = wen_cnt, r0 = ren_cnt, d0 = done_cnt, s0 = sof_cnt;
    set_ep(1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
    send_token(4'h9, 7'h06, 4'd1);
    repeat (10) @(posedge clk);
    send_token(4'h5, 7'h7f, 4'd0);
    @(negedge clk);
    vectors++;
    if (SOFRcvd !== 1'b1) begin
      miscompares++;
      $display("FAIL sof_timing: got %b want 1", SOFRcvd);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (wen_cnt - w0 !== 0 || ren_cnt - r0 !== 0 || done_cnt - d0 !== 0 || sof_cnt - s0 !== 1) begin
      miscompares++;
      $display("FAIL filter: got wen=%0d ren=%0d done=%0d sof=%0d want 0 0 0 1",
               wen_cnt - w0, ren_cnt - r0, done_cnt - d0, sof_cnt - s0);
    end
  endtask

  task automatic test_reset_mid;
    int w0 = wen_cnt, d0;
    set_ep(1'b1, 1'b0, 1'b0, 1'b1, 8'h40);
    sendPacketRdy = 1'b0;
    send_token(4'h9, 7'h05, 4'd2);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sendPacketWEn, getPacketREn, transDone, SOFRcvd, endPSel, sendPacketPID,
         transType, transResult} !== 16'h0000 || wen_cnt - w0 !== 0) begin
      miscompares++;
      $display("FAIL reset_mid: got ep=%0d type=%0d pid=%h wen=%0d want all 0",
               endPSel, transType, sendPacketPID, wen_cnt - w0);
    end
    sendPacketRdy = 1'b1;
    d0 = done_cnt;
    set_ep(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    send_token(4'h1, 7'h05, 4'd7);
    wait_done(d0);
    vectors++;
    if (last_pid !== 4'h2 || d_type !== 2'd2 || d_res !== 2'd0 || endPSel !== 4'd7) begin
      miscompares++;
      $display("FAIL reset_recover: got pid=%h type=%0d res=%0d ep=%0d want 2 2 0 7",
               last_pid, d_type, d_res, endPSel);
    end
  endtask

  task automatic test_back_to_back;
    int r0 = ren_cnt, w0 = wen_cnt, d0 = done_cnt;
    set_ep(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    getPacketRdy = 1'b0;
    send_token(4'h1, 7'h05, 4'd1);
    repeat (6) @(negedge clk);
    vectors++;
    if (ren_cnt - r0 !== 0) begin
      miscompares++;
      $display("FAIL rx_hold: got ren=%0d want 0 while RX busy", ren_cnt - r0);
    end
    getPacketRdy = 1'b1;
    wait_done(d0);
    d0 = done_cnt;
    set_ep(1'b1, 1'b0, 1'b0, 1'b0, 8'h41);
    send_token(4'h9, 7'h05, 4'd1);
    wait_done(d0);
    vectors++;
    if (ren_cnt - r0 !== 2 || wen_cnt - w0 !== 2 || last_pid !== 4'h3 || d_res !== 2'd3) begin
      miscompares++;
      $display("FAIL back_to_back: got ren=%0d wen=%0d pid=%h res=%0d want 2 2 3 3",
               ren_cnt - r0, wen_cnt - w0, last_pid, d_res);
    end
    vectors++;
    if (viol !== 0) begin
      miscompares++;
      $display("FAIL strobe_rules: got %0d violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_in_ack();
    test_out_stall();
    test_setup();
    test_out_crc();
    test_in_nak_timing();
    test_in_iso();
    test_filter();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_dev_trans_ctrl.md
# usb_dev_trans_ctrl

Device-side USB transaction controller: the responder for the host transaction FSM that issues SETUP/IN/OUT tokens. It decodes received tokens addressed to this device, then runs the data and handshake phases through the shared send-packet and get-packet engines. It reports every completed transaction to the endpoint/buffer layer as a one-cycle done pulse with type and result. It sits between the packet RX/TX processors and the endpoint control block.

## Interface

- No parameters.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- tokenRdy  in  1  one-cycle pulse: the token decoder has a valid token in tokenPID/tokenAddr/tokenEndP.
- tokenPID  in  4  token PID: OUT 4'h1, IN 4'h9, SOF 4'h5, SETUP 4'hd.
- tokenAddr  in  7  token device address.
- tokenEndP  in  4  token endpoint number.
- devAddr  in  7  this device's assigned address.
- endPSel  out  4  registered endpoint of the current transaction.
- epReady  in  1  the selected endpoint has a buffer (IN: data present; OUT: space free).
- epStall  in  1  the selected endpoint is halted.
- epIsoEn  in  1  the selected endpoint is isochronous.
- epDataSeq  in  1  DATA toggle for IN: 0 selects DATA0 (4'h3), 1 selects DATA1 (4'hb).
- sendPacketRdy  in  1  TX engine idle.
- sendPacketWEn  out  1  one-cycle send strobe.
- sendPacketPID  out  4  PID to send; held until the next send.
- getPacketRdy  in  1  RX engine idle or finished.
- getPacketREn  out  1  one-cycle receive strobe.
- RXStatus  in  8  bits[5:0] are error flags (any set = bad packet); bit 6 = an ACK handshake was received.
- SOFRcvd  out  1  one-cycle pulse on a SOF token addressed to any device.
- transDone  out  1  one-cycle completion pulse.
- transType  out  2  0 SETUP, 1 IN, 2 OUT; held after transDone.
- transResult  out  2  0 ACK/OK, 1 NAK, 2 STALL, 3 ERROR; held after transDone.

## Operation

- **Reset values:** all outputs are 0; the FSM goes to IDLE.
- **IDLE**
  - On tokenRdy with PID SOF: pulse SOFRcvd and stay in IDLE. The address is not checked.
  - On tokenRdy with tokenAddr == devAddr and PID in {SETUP, IN, OUT}: register endPSel and transType, then go to CHK_EP.
  - Any other token, or an address mismatch: ignore.
- **CHK_EP** (one cycle; the ep* inputs are valid here):
  - IN, epStall: respond STALL.
  - IN, !epReady, iso: no packet is sent; go to DONE with result NAK.
  - IN, !epReady, non-iso: respond NAK.
  - IN, epReady: send data. Iso always uses DATA0; non-iso uses epDataSeq.
  - SETUP or OUT: go to RX_REQ.
- **Send sequence** (data or handshake):
  - Wait for sendPacketRdy.
  - Pulse sendPacketWEn and load sendPacketPID in the same cycle.
  - Drop WEn for one cycle.
  - Wait for sendPacketRdy again.
- **Handshake PIDs:** ACK 4'h2, NAK 4'ha, STALL 4'he.
- **RX_REQ:** wait for getPacketRdy, then pulse getPacketREn. Drop REn the next cycle, then wait for getPacketRdy.
- **After OUT/SETUP data is received:**
  - RXStatus[5:0] != 0: no handshake; result ERROR.
  - iso: no handshake; result ACK.
  - SETUP: always send ACK (result ACK), regardless of epStall/epReady.
  - OUT, stall: send STALL.
  - OUT, !ready: send NAK.
  - OUT, otherwise: send ACK.
- **After an IN data send:**
  - iso: go straight to DONE with result ACK.
  - Non-iso: run a receive sequence for the host handshake. RXStatus[6]=1 and [5:0]=0 gives result ACK; anything else gives ERROR.
- **DONE:** pulse transDone for one cycle, then return to IDLE.
- tokenRdy is ignored outside IDLE.
- An rst mid-transaction aborts immediately: WEn and REn return to 0 and the FSM goes to IDLE.

## Timing

- tokenRdy to CHK_EP: 1 cycle. CHK_EP to the first WEn/REn: at least 1 cycle, more while the engine is not Rdy.
- WEn and REn are never asserted for more than 1 consecutive cycle.
- WEn and REn are never asserted in the same cycle.
- transType is valid from the cycle after tokenRdy. transResult is valid no later than the transDone cycle.
- Minimum IN-NAK transaction (Rdy held high): tokenRdy → CHK_EP → WEn → drop → wait → DONE. transDone is 5 cycles after tokenRdy.
- SOFRcvd is asserted the cycle after tokenRdy.

## Test plan

- **IN, ready, non-iso, epDataSeq=1, host ACK:**
  - Stimulus: devAddr=7'h05, IN token to addr 5 / endP 2; host returns RXStatus=8'h40.
  - Required: endPSel=2; one WEn with PID 4'hb; one REn; transDone with type 1, result 0.
- **OUT with epStall=1, clean data (RXStatus=0):**
  - Required: one REn, then WEn with PID 4'he; result 2.
- **SETUP with epReady=0, epStall=1:**
  - Required: ACK 4'h2 still sent; type 0, result 0.
- **OUT with RXStatus=8'h01 (CRC error):**
  - Required: no WEn after REn; result 3.
- **Filtering:**
  - Stimulus: token to addr 6 with devAddr 5; then SOF.
  - Required: no WEn/REn/transDone; SOFRcvd pulses exactly once.
- **Reset mid-transaction:**
  - Stimulus: rst while waiting for sendPacketRdy in an IN send.
  - Required: all outputs 0 the next cycle; a subsequent valid token is serviced normally.
